// File: rtl/nios_system_led_pkg.sv
// nios_system_led_pkg: register addresses and parameter limits for the LED PIO
package nios_system_led_pkg;
  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLEAR  = 3'd2;
  localparam logic [2:0] ADDR_BLINK  = 3'd3;
  localparam logic [2:0] ADDR_PERIOD = 3'd4;
  localparam logic [2:0] ADDR_DUTY   = 3'd5;
  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;
endpackage

// File: rtl/nios_system_led_timebase.sv
// nios_system_led_timebase: blink half-period prescaler and free-running PWM counter
module nios_system_led_timebase #(
  parameter int DIV_W = 24,
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] period,
  input  logic [PWM_W-1:0] duty,
  input  logic             restart,
  output logic             phase,
  output logic             pwm_on
);
  logic [DIV_W-1:0] div_cnt;
  logic [PWM_W-1:0] pwm_cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      div_cnt <= '0;
      pwm_cnt <= '0;
      phase   <= 1'b1;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (restart) begin
        div_cnt <= '0;
        phase   <= 1'b1;
      end else if (div_cnt == period) begin
        div_cnt <= '0;
        phase   <= ~phase;
      end else
        div_cnt <= div_cnt + 1'b1;
    end
  // all-ones duty is forced on so full brightness has no dark slot
  assign pwm_on = (&duty) | (pwm_cnt < duty);
endmodule

// File: rtl/nios_system_led_pio.sv
// nios_system_led_pio: Avalon-MM LED PIO with SET/CLEAR, per-channel blink and PWM dimming
module nios_system_led_pio
  import nios_system_led_pkg::*;
#(
  parameter int WIDTH     = 18,
  parameter int DIV_W     = 24,
  parameter int PWM_W     = 8,
  parameter int BLINK_RST = 12_499_999
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             blink_phase
);
  logic [WIDTH-1:0] data, blink_en;
  logic [DIV_W-1:0] period;
  logic [PWM_W-1:0] duty;
  logic             wr, pwm_on;
  assign wr = chipselect & ~write_n;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      data     <= '0;
      blink_en <= '0;
      period   <= DIV_W'(BLINK_RST);
      duty     <= '1;
      out_port <= '0;
    end else begin
      if (wr)
        case (address)
          ADDR_DATA:   data     <= writedata[WIDTH-1:0];
          ADDR_SET:    data     <= data | writedata[WIDTH-1:0];
          ADDR_CLEAR:  data     <= data & ~writedata[WIDTH-1:0];
          ADDR_BLINK:  blink_en <= writedata[WIDTH-1:0];
          ADDR_PERIOD: period   <= writedata[DIV_W-1:0];
          ADDR_DUTY:   duty     <= writedata[PWM_W-1:0];
          default: ;
        endcase
      out_port <= data & (~blink_en | {WIDTH{blink_phase}}) & {WIDTH{pwm_on}};
    end
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA, ADDR_SET, ADDR_CLEAR: readdata[WIDTH-1:0] = data;
      ADDR_BLINK:  readdata[WIDTH-1:0] = blink_en;
      ADDR_PERIOD: readdata[DIV_W-1:0] = period;
      ADDR_DUTY:   readdata[PWM_W-1:0] = duty;
      default: ;
    endcase
  end
  nios_system_led_timebase #(.DIV_W(DIV_W), .PWM_W(PWM_W)) u_timebase (
    .clk     (clk),
    .reset_n (reset_n),
    .period  (period),
    .duty    (duty),
    .restart (wr && address == ADDR_PERIOD),
    .phase   (blink_phase),
    .pwm_on  (pwm_on)
  );
endmodule

// File: tb/tb_nios_system_led_pio.sv
// tb_nios_system_led_pio: scoreboard bench for the LED PIO register map, blink and PWM
module tb_nios_system_led_pio;
  localparam logic [31:0] BLINK_RST = 32'd12_499_999;
  logic        clk = 0, reset_n = 0, chipselect = 0, write_n = 1;
  logic [2:0]  address = 0;
  logic [31:0] writedata = 0, readdata;
  logic [17:0] out_port;
  logic        blink_phase;
  int          n_vec = 0, n_err = 0;
  string       tq[$];
  logic [31:0] vq[$];

  nios_system_led_pio dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .out_port    (out_port),
    .blink_phase (blink_phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    tq.push_back(tag);
    vq.push_back(v);
  endtask

  task automatic pop(input logic [31:0] got);
    if (vq.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard: empty, got %h", got);
    end else
      chk(tq.pop_front(), got, vq.pop_front());
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1; write_n = 0;
    @(negedge clk);
    chipselect = 0; write_n = 1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string tag);
    @(negedge clk);
    address = a; chipselect = 1; write_n = 1;
    push(tag, e);
    #1 pop(readdata);
    chipselect = 0;
  endtask

  task automatic wr_out(input logic [2:0] a, input logic [31:0] d, input logic [31:0] e, input string tag);
    wr(a, d);
    @(negedge clk);
    push(tag, e);
    #1 pop(32'(out_port));
  endtask

  task automatic pwm_run(input logic [31:0] d, input logic [31:0] e, input string tag);
    int cnt;
    wr(5, d);
    repeat (2) @(negedge clk);
    push(tag, e);
    cnt = 0;
    repeat (256) begin
      @(negedge clk);
      cnt += int'(out_port[0]);
    end
    pop(32'(cnt));
  endtask

  function automatic logic ph(input int j);
    return ((j / 4) % 2) == 0;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    push("rst_out", 0);        #1 pop(32'(out_port));
    push("rst_phase", 1);      pop(32'(blink_phase));
    reset_n = 1;
    rd(4, BLINK_RST, "rst_period");
    rd(5, 32'hFF, "rst_duty");
    rd(0, 0, "rst_data");
    rd(3, 0, "rst_blink_en");

    wr(0, 32'h3FFFF);
    push("data_latency", 0);   #1 pop(32'(out_port));
    @(negedge clk);
    push("data_out", 32'h3FFFF); #1 pop(32'(out_port));
    wr_out(2, 32'h0000F, 32'h3FFF0, "clear_out");
    wr_out(1, 32'h00003, 32'h3FFF3, "set_out");
    rd(0, 32'h3FFF3, "rd_data");
    rd(1, 32'h3FFF3, "rd_set_alias");
    rd(2, 32'h3FFF3, "rd_clear_alias");
    wr(0, 32'hFFFF_FFFF);
    rd(0, 32'h3FFFF, "data_mask");
    wr(2, 32'h30);
    wr(1, 32'h10);
    rd(0, 32'h3FFDF, "clear_then_set");

    rd(6, 0, "rd_rsv6");
    rd(7, 0, "rd_rsv7");
    wr(6, 32'hFFFF_FFFF);
    rd(0, 32'h3FFDF, "rsv_data");
    rd(3, 0, "rsv_blink_en");
    rd(4, BLINK_RST, "rsv_period");
    rd(5, 32'hFF, "rsv_duty");

    wr(0, 32'h3);
    wr(3, 32'h1);
    wr(4, 32'h3);
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      push("blink_out", {30'b0, 1'b1, ph(j - 1)});
      push("blink_phase", {31'b0, ph(j)});
      #1 pop(32'(out_port));
      pop(32'(blink_phase));
    end
    rd(4, 32'h3, "rd_period");
    rd(3, 32'h1, "rd_blink_en");

    repeat (2) @(negedge clk);
    #2 reset_n = 0;
    #1;
    push("arst_out", 0);       pop(32'(out_port));
    push("arst_phase", 1);     pop(32'(blink_phase));
    @(negedge clk);
    reset_n = 1;
    rd(0, 0, "arst_data");
    rd(3, 0, "arst_blink_en");
    rd(4, BLINK_RST, "arst_period");

    wr(0, 32'h1);
    pwm_run(32'hFFFF_FF40, 64, "pwm_40");
    rd(5, 32'h40, "duty_mask");
    pwm_run(32'h80, 128, "pwm_80");
    pwm_run(32'h00, 0, "pwm_00");
    pwm_run(32'hFF, 256, "pwm_ff");

    if (vq.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard: %0d entries left, expected 0", vq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
